// File: rtl/buzzer_sequencer.sv
// Score player: fetches two-word events over the DMA read port, issues buzzer commands and timed delays.
// Optional looping scores (JUMP opcode 0xFE) are enabled by defining BUZZER_SEQ_LOOP_EN.
module buzzer_sequencer #(
    parameter int unsigned TICK_DIV = 50000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        play,
    input  logic [15:0] playAddr,
    input  logic        stop,
    output logic [15:0] addrDMA,
    output logic        startDMA,
    input  logic [15:0] inDMA,
    input  logic        rdyDMA,
    output logic [23:0] cmdOut,
    output logic        cmdValid,
    output logic        busy,
    output logic        done
);

    localparam int unsigned PRESC_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    typedef enum logic [2:0] {
        IDLE, FETCH0, WAIT0, FETCH1, WAIT1, ISSUE, DELAY, FLUSH
    } state_t;

    state_t               state, stateNext;
    logic [15:0]          ptr, ptrNext;
    logic [7:0]           opcode, opcodeNext;
    logic [7:0]           delay, delayNext;
    logic [15:0]          payload, payloadNext;
    logic [PRESC_W-1:0]   presc, prescNext;
    logic [7:0]           ticks, ticksNext;
    logic [1:0]           flushIdx, flushIdxNext;
    logic                 stopPend, stopPendNext;

    logic                 isEnd;
    logic                 startNext, cmdValidNext, busyNext, doneNext;
    logic [15:0]          addrNext;
    logic [23:0]          cmdNext;

`ifdef BUZZER_SEQ_LOOP_EN
    logic isJump;
    assign isJump = (opcode == 8'hFE);
    assign isEnd  = (opcode == 8'hFF);
`else
    assign isEnd  = (opcode == 8'hFF) || (opcode == 8'hFE);
`endif

    // State, pointer, event capture and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            ptr      <= 16'd0;
            opcode   <= 8'd0;
            delay    <= 8'd0;
            payload  <= 16'd0;
            presc    <= '0;
            ticks    <= 8'd0;
            flushIdx <= 2'd0;
            stopPend <= 1'b0;
            addrDMA  <= 16'd0;
            startDMA <= 1'b0;
            cmdOut   <= 24'd0;
            cmdValid <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= stateNext;
            ptr      <= ptrNext;
            opcode   <= opcodeNext;
            delay    <= delayNext;
            payload  <= payloadNext;
            presc    <= prescNext;
            ticks    <= ticksNext;
            flushIdx <= flushIdxNext;
            stopPend <= stopPendNext;
            addrDMA  <= addrNext;
            startDMA <= startNext;
            cmdOut   <= cmdNext;
            cmdValid <= cmdValidNext;
            busy     <= busyNext;
            done     <= doneNext;
        end
    end

    // Next-state and next-output decode
    always_comb begin
        stateNext    = state;
        ptrNext      = ptr;
        opcodeNext   = opcode;
        delayNext    = delay;
        payloadNext  = payload;
        prescNext    = presc;
        ticksNext    = ticks;
        flushIdxNext = 2'd0;
        stopPendNext = 1'b0;

        case (state)
            IDLE: begin
                if (play && !stop) begin
                    ptrNext   = playAddr;
                    stateNext = FETCH0;
                end
            end
            FETCH0: stateNext = stop ? FLUSH : WAIT0;
            WAIT0: begin
                stopPendNext = stopPend | stop;
                if (rdyDMA) begin
                    stopPendNext = 1'b0;
                    if (stopPend || stop) begin
                        stateNext = FLUSH;
                    end else begin
                        opcodeNext = inDMA[15:8];
                        delayNext  = inDMA[7:0];
                        ptrNext    = ptr + 16'd1;
                        stateNext  = FETCH1;
                    end
                end
            end
            FETCH1: stateNext = stop ? FLUSH : WAIT1;
            WAIT1: begin
                stopPendNext = stopPend | stop;
                if (rdyDMA) begin
                    stopPendNext = 1'b0;
                    if (stopPend || stop) begin
                        stateNext = FLUSH;
                    end else begin
                        payloadNext = inDMA;
                        ptrNext     = ptr + 16'd1;
                        stateNext   = ISSUE;
                    end
                end
            end
            ISSUE: begin
                if (stop || isEnd) begin
                    stateNext = FLUSH;
`ifdef BUZZER_SEQ_LOOP_EN
                end else if (isJump) begin
                    ptrNext   = payload;
                    stateNext = FETCH0;
`endif
                end else if (delay == 8'd0) begin
                    stateNext = FETCH0;
                end else begin
                    prescNext = '0;
                    ticksNext = delay;
                    stateNext = DELAY;
                end
            end
            DELAY: begin
                if (stop) begin
                    stateNext = FLUSH;
                end else if (presc == PRESC_W'(TICK_DIV - 1)) begin
                    prescNext = '0;
                    ticksNext = ticks - 8'd1;
                    if (ticks == 8'd1) stateNext = FETCH0;
                end else begin
                    prescNext = presc + PRESC_W'(1);
                end
            end
            FLUSH: begin
                if (flushIdx == 2'd2) stateNext = IDLE;
                else                  flushIdxNext = flushIdx + 2'd1;
            end
            default: stateNext = IDLE;
        endcase

        // Outputs are decoded from the upcoming state so they appear registered in that state
        startNext    = (stateNext == FETCH0) || (stateNext == FETCH1);
        addrNext     = startNext ? ptrNext : 16'd0;
        cmdValidNext = 1'b0;
        cmdNext      = 24'd0;
        if (stateNext == FLUSH) begin
            cmdValidNext = 1'b1;
            cmdNext      = {8'h02, 14'd0, flushIdxNext};
        end else if (stateNext == ISSUE && opcodeNext <= 8'd9) begin
            cmdValidNext = 1'b1;
            cmdNext      = {opcodeNext, payloadNext};
        end
        busyNext = (stateNext != IDLE);
        doneNext = (state == FLUSH) && (stateNext == IDLE);
    end

endmodule

// File: doc/buzzer_sequencer.md
# buzzer_sequencer

Score player that drives the `Buzzer16` command port. It fetches a stored score from memory over the 16-bit DMA read handshake. Each event is decoded into a 24-bit buzzer command, emitted as a one-cycle `cmdValid` pulse, and followed by a programmed delay in ticks. It sits between the memory/DMA arbiter and the buzzer, so the CPU only starts and stops playback.

## Interface
Parameters:
- `TICK_DIV`, default 50000: clock cycles per delay tick (≥1).

Ports:
- `clk`  in  1: system clock; the only clock.
- `rst`  in  1: reset, synchronous, active-high.
- `play`  in  1: one-cycle pulse that starts playback at `playAddr`.
- `playAddr`  in  16: word address of the first event.
- `stop`  in  1: one-cycle pulse that aborts playback.
- `addrDMA`  out  16: read word address; valid while `startDMA`=1.
- `startDMA`  out  1: one-cycle read request.
- `inDMA`  in  16: read data; valid while `rdyDMA`=1.
- `rdyDMA`  in  1: read-complete strobe.
- `cmdOut`  out  24: command to the buzzer `in`.
- `cmdValid`  out  1: one-cycle pulse to the buzzer `start`.
- `busy`  out  1: high in every state except IDLE.
- `done`  out  1: one-cycle pulse on return to IDLE.

## Operation
Event format: two consecutive 16-bit words.
- Word0: `[15:8]` is the opcode; `[7:0]` is the delay in ticks.
- Word1: the 16-bit payload.
- Buzzer opcodes are 0–9. For these, `cmdOut = {opcode, payload}`.
- Opcode 0xFF is END.
- Opcode 0xFE is JUMP, with target = payload.
- Other unknown opcodes are skipped: no `cmdValid`, but the delay is still applied.

State machine:
- IDLE → FETCH0 on `play`. The pointer is loaded with `playAddr`.
- FETCH0: `startDMA`=1 with `addrDMA`=ptr for one cycle → WAIT0.
- WAIT0: on `rdyDMA`, capture opcode and delay; ptr+1 → FETCH1.
- FETCH1 / WAIT1: same handshake; capture the payload; ptr+1 → ISSUE.
- ISSUE, branching on the captured opcode:
  - opcode ≤ 9: `cmdValid`=1 for one cycle.
  - END: → FLUSH.
  - JUMP: ptr = payload → FETCH0. The JUMP delay is ignored.
  - Otherwise, with delay = 0: → FETCH0.
  - Otherwise, with delay ≠ 0: → DELAY.
- DELAY: the prescaler restarts on entry. The state lasts exactly delay×TICK_DIV cycles → FETCH0.
- FLUSH: emits three `cmdValid` pulses on consecutive cycles, `cmdOut` = 0x020000, 0x020001, 0x020002 (STOP on channels 0, 1, 2) → IDLE with `done`=1.

Rules:
- Pointer arithmetic is 16-bit and wraps 0xFFFF → 0x0000.
- At most one DMA read is outstanding. `rdyDMA` outside WAIT0/WAIT1 is ignored.
- `play` while `busy` is ignored.
- `stop` in FETCH*, ISSUE or DELAY → FLUSH on the next cycle; the pending event is discarded.
- `stop` in WAIT*: the FSM waits for `rdyDMA`, discards the data, then → FLUSH.
- `stop` in FLUSH or IDLE is ignored.
- `play` and `stop` in the same IDLE cycle: both are ignored.
- `rst` at any point forces IDLE. A late `rdyDMA` after reset is ignored.

## Timing
- Reset values: `addrDMA`=0, `startDMA`=0, `cmdOut`=0, `cmdValid`=0, `busy`=0, `done`=0. The pointer and prescaler are also 0.
- All outputs are registered. `cmdOut` holds 0 except in cycles where `cmdValid`=1.
- `play` at cycle N → `startDMA` at N+1.
- `rdyDMA` at cycle M → next `startDMA` at M+1.
- Word1 `rdyDMA` at cycle M → `cmdValid` at M+1 → next FETCH0 `startDMA` at M+2 when delay = 0.
- With delay d ≠ 0: `startDMA` at M+2+d×TICK_DIV.
- END: word1 `rdyDMA` at M → flush pulses at M+2, M+3, M+4 → `done` at M+5, with `busy`=0 from M+5.
- `rdyDMA` may arrive any number of cycles (≥1) after `startDMA`, with no timeout.

## Configuration
Macro `BUZZER_SEQ_LOOP_EN`:
- Defined: JUMP (0xFE) is decoded as above, allowing looping scores.
- Undefined: 0xFE is treated exactly as END, and the JUMP logic is not synthesised.

## Test plan
All scenarios use `TICK_DIV`=4 and a memory model answering `rdyDMA` 2 cycles after `startDMA`.
- **Single event + END.** Score at 0x0100: `{0x0100, 0x0025}`, `{0xFF00, 0x0000}` → one `cmdValid` with `cmdOut`=0x010025, then 0x020000/0x020001/0x020002 on consecutive cycles, then `done`. Reads hit 0x0100–0x0103.
- **Delay.** Event word0 = 0x0103 (NOTE, delay 3) → exactly 12 cycles in DELAY; next `startDMA` 14 cycles after the word1 `rdyDMA`.
- **Wrap.** `playAddr`=0xFFFF → word1 is read from 0x0000, next event from 0x0001.
- **JUMP.** With `BUZZER_SEQ_LOOP_EN`, score `{0x0300, 0x0005}`, `{0xFE00, 0x0100}` at 0x0100 → VOL 0x030005 repeats every loop. Without the macro → one VOL command, flush, `done`.
- **Stop mid-read.** `stop` while in WAIT1 → no `cmdValid` for that event; the flush starts 1 cycle after `rdyDMA`.
- **Edge inputs.** `play` while `busy` → no effect. `rst` asserted in DELAY → all outputs 0 next cycle; a stray `rdyDMA` afterwards produces no activity.
